// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 window generator that feeds the Sobel gradient stage, using two row line buffers
module sobel_window_gen #(
  parameter int WIDTH = 512,
  parameter int HEIGHT = 512,
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic            in_sof,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [9*DW-1:0] out_data,
  output logic [15:0]     out_x,
  output logic [15:0]     out_y,
  output logic            out_eof,
  output logic            frame_done,
  output logic            sof_err
);
  localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [15:0] XL = 16'(WIDTH - 1);
  localparam logic [15:0] YL = 16'(HEIGHT - 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t st_q;
  logic [15:0] col_q, row_q, c, r;
  logic [DW-1:0] lb0 [WIDTH];
  logic [DW-1:0] lb1 [WIDTH];
  logic [9*DW-1:0] win_q, win_d;
  logic [AW-1:0] ci;
  logic acc, proc, last, emit;
  assign in_ready = !(out_valid && !out_ready);
  assign acc = in_valid && in_ready;
  assign proc = acc && (in_sof || st_q == ACTIVE);
  assign c = in_sof ? '0 : col_q;
  assign r = in_sof ? '0 : row_q;
  assign ci = c[AW-1:0];
  assign last = c == XL && r == YL;
  assign emit = proc && c >= 16'd2 && r >= 16'd2;
  assign out_data = win_q;
  always_comb begin
    win_d = win_q;
    for (int k = 0; k < 3; k++) begin
      win_d[DW*3*k +: DW] = win_q[DW*(3*k+1) +: DW];
      win_d[DW*(3*k+1) +: DW] = win_q[DW*(3*k+2) +: DW];
    end
    win_d[DW*2 +: DW] = lb1[ci];
    win_d[DW*5 +: DW] = lb0[ci];
    win_d[DW*8 +: DW] = in_data;
  end
  always_ff @(posedge clk) begin
    if (proc) begin
      lb1[ci] <= lb0[ci];
      lb0[ci] <= in_data;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q       <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      win_q      <= '0;
      out_valid  <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_eof    <= 1'b0;
      frame_done <= 1'b0;
      sof_err    <= 1'b0;
    end else begin
      frame_done <= proc && last;
      sof_err    <= acc && in_sof && st_q == ACTIVE;
      out_valid  <= emit ? 1'b1 : out_ready ? 1'b0 : out_valid;
      if (proc) begin
        st_q  <= last ? IDLE : ACTIVE;
        col_q <= c == XL ? '0 : c + 16'd1;
        row_q <= c != XL ? r : last ? '0 : r + 16'd1;
        win_q <= win_d;
      end
      if (emit) begin
        out_x   <= c - 16'd1;
        out_y   <= r - 16'd1;
        out_eof <= last;
      end
    end
  end
endmodule
